core_wb_responder: RTL and testbench

Wishbone slave response path for the 256x256 neuron core: the completion side of the core address decode. It consumes the decoded selects (slice one-hot, choose_weight, picture_done, send_spike) and sequences each transaction. It waits for SRAM read latency or for all slices to accept a spike broadcast, muxes read data, generates wbs_ack_o, and owns the picture-done pulse and picture counter.

---
 rtl/core_wb_responder.sv | 113 +++++++++++
 tb/tb_core_wb_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_wb_responder.sv
// core_wb_responder: Wishbone completion path for the neuron core.
// Sequences decoded accesses, waits on slice read latency or spike broadcast, drives ack/data.
module core_wb_responder #(
    parameter int NUM_OF_SLICE  = 8,
    parameter int READ_LATENCY  = 1,
    parameter int SPIKE_TIMEOUT = 255,
    parameter int CNT_W         = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [31:0]                wbs_adr_i,
    output logic [31:0]                wbs_dat_o,
    output logic                       wbs_ack_o,
    input  logic [NUM_OF_SLICE-1:0]    slice,
    input  logic                       choose_weight,
    input  logic                       picture_done,
    input  logic                       send_spike,
    input  logic [32*NUM_OF_SLICE-1:0] slice_rdata_i,
    input  logic [NUM_OF_SLICE-1:0]    spike_ready_i,
    input  logic [31:0]                weight_rdata_i,
    output logic                       spike_valid_o,
    output logic                       pic_done_o,
    output logic                       timeout_err_o
);
    localparam int WAIT_W = $clog2(SPIKE_TIMEOUT + 8);

    typedef enum logic [1:0] {IDLE, RD_WAIT, SPIKE_WAIT, ACK} state_t;

    state_t                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [NUM_OF_SLICE-1:0] slice_q, slice_d;
    logic [CNT_W-1:0]        pic_cnt_q, pic_cnt_d;
    logic                    pic_done_q, pic_done_d;
    logic                    err_q, err_d;
    logic [31:0]             dat_q, dat_d;
    logic [31:0]             rd_mux;
    logic                    req, rd_hit, all_ready, timed_out, pic_wr;
    logic                    unused_adr;

    // Address decode happens upstream; only the selects matter here.
    assign unused_adr = ^wbs_adr_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            slice_q    <= '0;
            pic_cnt_q  <= '0;
            pic_done_q <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            slice_q    <= slice_d;
            pic_cnt_q  <= pic_cnt_d;
            pic_done_q <= pic_done_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
        end
    end

    // Later loop iterations win, so the lowest set slice bit selects the data.
    always_comb begin
        rd_mux = weight_rdata_i;
        for (int k = NUM_OF_SLICE - 1; k >= 0; k--)
            if (slice_q[k]) rd_mux = slice_rdata_i[32*k +: 32];
    end

    always_comb begin
        req       = wbs_cyc_i & wbs_stb_i;
        rd_hit    = ~wbs_we_i & ((|slice) | choose_weight);
        all_ready = &spike_ready_i;
        timed_out = wait_q == WAIT_W'(SPIKE_TIMEOUT - 1);
        state_d   = state_q;
        wait_d    = wait_q;
        slice_d   = slice_q;
        case (state_q)
            IDLE: if (req) begin
                slice_d = slice;
                wait_d  = send_spike ? '0 : WAIT_W'(READ_LATENCY - 1);
                state_d = send_spike ? SPIKE_WAIT : rd_hit ? RD_WAIT : ACK;
            end
            RD_WAIT: begin
                wait_d  = wait_q - 1'b1;
                state_d = !wbs_cyc_i ? IDLE : (wait_q == '0) ? ACK : RD_WAIT;
            end
            SPIKE_WAIT: begin
                wait_d  = wait_q + 1'b1;
                state_d = !wbs_cyc_i ? IDLE : (all_ready | timed_out) ? ACK : SPIKE_WAIT;
            end
            default: state_d = IDLE;
        endcase
        pic_wr     = state_q == IDLE && req && !send_spike && picture_done && wbs_we_i;
        pic_done_d = pic_wr;
        pic_cnt_d  = pic_cnt_q + CNT_W'(pic_wr);
        err_d      = err_q | (state_q == SPIKE_WAIT && wbs_cyc_i && !all_ready && timed_out);
        dat_d      = state_d != ACK ? dat_q :
                     state_q == RD_WAIT ? rd_mux :
                     (state_q == IDLE && !wbs_we_i && picture_done) ? 32'(pic_cnt_q) : '0;
    end

    always_comb begin
        wbs_ack_o     = state_q == ACK;
        spike_valid_o = state_q == SPIKE_WAIT;
        wbs_dat_o     = dat_q;
        pic_done_o    = pic_done_q;
        timeout_err_o = err_q;
    end
endmodule

// File: tb/tb_core_wb_responder.sv
// tb_core_wb_responder: directed bench; a second instance covers READ_LATENCY=4 and counter wrap.
module tb_core_wb_responder;
    logic         clk = 0, rst = 0;
    logic         cyc = 0, stb = 0, cyc2 = 0, stb2 = 0;
    logic         we = 0, cw = 0, pd = 0, ss = 0;
    logic [31:0]  adr = 0, wrd = 32'h1234_5678;
    logic [7:0]   slice = 0, sready = 0;
    logic [255:0] srd;
    logic [31:0]  dat1, dat2;
    logic         ack1, ack2, sv1, sv2, pdo1, pdo2, te1, te2;
    int           errors = 0, checks = 0, n;

    always #5 clk = ~clk;

    core_wb_responder dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_o(dat1), .wbs_ack_o(ack1),
        .slice(slice), .choose_weight(cw), .picture_done(pd), .send_spike(ss),
        .slice_rdata_i(srd), .spike_ready_i(sready), .weight_rdata_i(wrd),
        .spike_valid_o(sv1), .pic_done_o(pdo1), .timeout_err_o(te1)
    );

    core_wb_responder #(.READ_LATENCY(4), .CNT_W(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc2), .wbs_stb_i(stb2),
        .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_o(dat2), .wbs_ack_o(ack2),
        .slice(slice), .choose_weight(cw), .picture_done(pd), .send_spike(ss),
        .slice_rdata_i(srd), .spike_ready_i(sready), .weight_rdata_i(wrd),
        .spike_valid_o(sv2), .pic_done_o(pdo2), .timeout_err_o(te2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        cyc = 0; stb = 0; cyc2 = 0; stb2 = 0;
        we = 0; cw = 0; pd = 0; ss = 0; slice = 0; adr = 0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) srd[32*k +: 32] = 32'hA5A5_0000 | 32'(k);
        #1 rst = 1;
        #1;
        chk("rst_ack", ack1, 0);
        chk("rst_dat", dat1, 0);
        chk("rst_sv", sv1, 0);
        chk("rst_pd", pdo1, 0);
        chk("rst_te", te1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();

        // read slice 3, latency 1
        cyc = 1; stb = 1; we = 0; slice = 8'h08;
        tick();
        chk("rd3_wait", ack1, 0);
        tick();
        chk("rd3_ack", ack1, 1);
        chk("rd3_dat", dat1, 32'hA5A5_0003);
        idle_bus();
        tick();
        chk("rd3_ack_single", ack1, 0);
        chk("rd3_dat_hold", dat1, 32'hA5A5_0003);

        // spike broadcast, all ready in the fifth wait cycle
        cyc = 1; stb = 1; we = 1; ss = 1; slice = 8'hFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("sp_valid", sv1, 1);
            chk("sp_noack", ack1, 0);
            if (i == 4) sready = 8'hFF;
            tick();
        end
        chk("sp_ack", ack1, 1);
        chk("sp_valid_drop", sv1, 0);
        chk("sp_dat", dat1, 0);
        chk("sp_te", te1, 0);
        idle_bus();
        sready = 0;
        tick();

        // spike broadcast that never completes
        cyc = 1; stb = 1; we = 1; ss = 1; slice = 8'hFF; sready = 8'h7F;
        tick();
        n = 0;
        while (sv1 === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 255);
        chk("to_ack", ack1, 1);
        chk("to_te", te1, 1);
        idle_bus();
        sready = 0;
        tick();
        chk("to_sticky", te1, 1);

        // three picture-done writes then a read of the counter
        for (int i = 0; i < 3; i++) begin
            cyc = 1; stb = 1; we = 1; pd = 1; adr = 32'h3000_0840;
            tick();
            chk("pd_pulse", pdo1, 1);
            chk("pd_ack", ack1, 1);
            idle_bus();
            tick();
            chk("pd_pulse_end", pdo1, 0);
        end
        cyc = 1; stb = 1; we = 0; pd = 1; adr = 32'h3000_0840;
        tick();
        chk("pd_rd_ack", ack1, 1);
        chk("pd_rd_dat", dat1, 3);
        chk("pd_rd_nopulse", pdo1, 0);
        idle_bus();
        tick();

        // unmapped read: no selects
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_FFF0;
        tick();
        chk("um_ack", ack1, 1);
        chk("um_dat", dat1, 0);
        chk("um_te", te1, 1);
        idle_bus();
        tick();

        // weight register read
        cyc = 1; stb = 1; we = 0; cw = 1;
        tick();
        tick();
        chk("cw_ack", ack1, 1);
        chk("cw_dat", dat1, 32'h1234_5678);
        idle_bus();
        tick();

        // counter wrap on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            cyc2 = 1; stb2 = 1; we = 1; pd = 1;
            tick();
            idle_bus();
            tick();
        end
        cyc2 = 1; stb2 = 1; we = 0; pd = 1;
        tick();
        chk("wrap_ack", ack2, 1);
        chk("wrap_dat", dat2, 0);
        idle_bus();
        tick();

        // abort during RD_WAIT with latency 4
        cyc2 = 1; stb2 = 1; we = 0; slice = 8'h04;
        tick();
        tick();
        cyc2 = 0; stb2 = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ab_noack", ack2, 0);
        end
        cyc2 = 1; stb2 = 1; we = 0; slice = 8'h04;
        tick();
        n = 0;
        while (ack2 !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("rl4_latency", 32'(n), 4);
        chk("rl4_dat", dat2, 32'hA5A5_0002);
        idle_bus();
        tick();

        // back-to-back reads of slices 0 and 7 with strobe held
        cyc = 1; stb = 1; we = 0; slice = 8'h01;
        tick();
        chk("bb_wait0", ack1, 0);
        slice = 8'h80;
        tick();
        chk("bb_ack0", ack1, 1);
        chk("bb_dat0", dat1, 32'hA5A5_0000);
        tick();
        chk("bb_bubble", ack1, 0);
        tick();
        chk("bb_wait7", ack1, 0);
        tick();
        chk("bb_ack7", ack1, 1);
        chk("bb_dat7", dat1, 32'hA5A5_0007);
        idle_bus();
        tick();

        // asynchronous reset in the middle of RD_WAIT
        cyc2 = 1; stb2 = 1; we = 0; slice = 8'h02;
        tick();
        tick();
        #2 rst = 1;
        #1;
        chk("ar_ack2", ack2, 0);
        chk("ar_dat2", dat2, 0);
        chk("ar_dat1", dat1, 0);
        chk("ar_te1", te1, 0);
        chk("ar_sv1", sv1, 0);
        idle_bus();
        tick();
        rst = 0;
        tick();
        chk("ar_no_late_ack", ack2, 0);
        cyc = 1; stb = 1; we = 0; pd = 1;
        tick();
        chk("ar_cnt_cleared", dat1, 0);
        chk("ar_cnt_ack", ack1, 1);
        idle_bus();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
